// File: rtl/mips_encode.sv
// Encodes ALU-op requests into 32-bit MIPS words and queues them in a DEPTH-entry FIFO.
// Latency 1 cycle from acceptance to out_valid when empty; in_ready drops while the FIFO is full.
module mips_encode #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic             alu_src2,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [15:0]      imm16,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             except,
    output logic [ERR_W-1:0] err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             except_q, except_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic        enc_ok;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic [31:0] enc_inst;
    logic        accept, push, pop;

    // sub and nor have no immediate form in MIPS, so they are unencodable as I-type
    always_comb begin
        enc_ok = 1'b1;
        funct  = 6'h00;
        opcode = 6'h00;
        case (alu_op)
            3'd2: begin funct = 6'h20; opcode = 6'h08; end
            3'd3: begin funct = 6'h22; enc_ok = !alu_src2; end
            3'd4: begin funct = 6'h24; opcode = 6'h0c; end
            3'd5: begin funct = 6'h25; opcode = 6'h0d; end
            3'd6: begin funct = 6'h27; enc_ok = !alu_src2; end
            3'd7: begin funct = 6'h26; opcode = 6'h0e; end
            default: enc_ok = 1'b0;
        endcase
        enc_inst = alu_src2 ? {opcode, rs, rd, imm16}
                            : {6'h00, rs, rt, rd, 5'h00, funct};
    end

    assign in_ready  = reset && (cnt_q != FULL_CNT);
    assign out_valid = (cnt_q != '0);
    assign out_inst  = out_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign except    = except_q;
    assign err_count = err_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && enc_ok;
    assign pop    = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        except_d = accept && !enc_ok;
        err_d    = err_q;
        if (push) begin
            mem_d[wr_ptr_q] = enc_inst;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (accept && !enc_ok && !(&err_q)) begin
            err_d = err_q + ERR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            except_q <= 1'b0;
            err_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            except_q <= except_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mips_encode.sv
// Directed bench for mips_encode: vector table for single encodings, then FIFO fill/drain,
// streaming, mid-stream reset and error-counter saturation sequences.
module tb_mips_encode;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_op;
    logic        alu_src2;
    logic [4:0]  rd, rs, rt;
    logic [15:0] imm16;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        except;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mips_encode #(.DEPTH(4), .ERR_W(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .alu_src2(alu_src2),
        .rd(rd), .rs(rs), .rt(rt), .imm16(imm16),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .except(except), .err_count(err_count)
    );

    typedef struct {
        logic [2:0]  op;
        logic        src2;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic [31:0] exp_inst;
        logic        legal;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic [2:0] op, input logic s2, input logic [4:0] d,
                           input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
        alu_op = op; alu_src2 = s2; rd = d; rs = s; rt = t; imm16 = im;
    endtask

    function automatic logic [31:0] w(input int k);
        logic [4:0] d, s, t;
        d = 5'(k + 1); s = 5'(k + 2); t = 5'(k + 3);
        return {6'h00, s, t, d, 5'h00, 6'h20};
    endfunction

    task automatic req_add(input int k);
        set_req(3'd2, 1'b0, 5'(k + 1), 5'(k + 2), 5'(k + 3), 16'h0);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] tmp;
        logic [7:0]  err_exp;
        logic        acc, popping, acc5;

        vecs[0]  = '{3'd2, 1'b0, 5'd3,  5'd1,  5'd2,  16'hABCD, 32'h00221820, 1'b1};
        vecs[1]  = '{3'd3, 1'b0, 5'd10, 5'd8,  5'd9,  16'h1111, 32'h01095022, 1'b1};
        vecs[2]  = '{3'd4, 1'b0, 5'd31, 5'd31, 5'd31, 16'hFFFF, 32'h03FFF824, 1'b1};
        vecs[3]  = '{3'd5, 1'b0, 5'd0,  5'd0,  5'd0,  16'h0000, 32'h00000025, 1'b1};
        vecs[4]  = '{3'd6, 1'b0, 5'd7,  5'd6,  5'd5,  16'h5555, 32'h00C53827, 1'b1};
        vecs[5]  = '{3'd7, 1'b0, 5'd2,  5'd17, 5'd16, 16'h0000, 32'h02301026, 1'b1};
        vecs[6]  = '{3'd2, 1'b1, 5'd5,  5'd4,  5'd31, 16'hFFFF, 32'h2085FFFF, 1'b1};
        vecs[7]  = '{3'd4, 1'b1, 5'd1,  5'd2,  5'd7,  16'h00FF, 32'h304100FF, 1'b1};
        vecs[8]  = '{3'd5, 1'b1, 5'd9,  5'd3,  5'd0,  16'h1234, 32'h34691234, 1'b1};
        vecs[9]  = '{3'd7, 1'b1, 5'd31, 5'd31, 5'd3,  16'h8000, 32'h3BFF8000, 1'b1};
        vecs[10] = '{3'd6, 1'b1, 5'd1,  5'd1,  5'd1,  16'h0001, 32'h00000000, 1'b0};
        vecs[11] = '{3'd0, 1'b0, 5'd4,  5'd4,  5'd4,  16'h0000, 32'h00000000, 1'b0};
        vecs[12] = '{3'd3, 1'b1, 5'd2,  5'd3,  5'd4,  16'h00F0, 32'h00000000, 1'b0};
        vecs[13] = '{3'd1, 1'b1, 5'd6,  5'd7,  5'd8,  16'h0F00, 32'h00000000, 1'b0};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_req(3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0);
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_except",    32'(except),    32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_inst",  out_inst,       32'h0);
        reset = 1'b1;
        tick();

        // Single encodings on an empty FIFO
        err_exp = 8'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            set_req(vecs[i].op, vecs[i].src2, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].imm);
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            if (!vecs[i].legal) err_exp = err_exp + 8'd1;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].legal));
            check($sformatf("v%0d_except", i), 32'(except), 32'(!vecs[i].legal));
            check($sformatf("v%0d_out_inst", i), out_inst, vecs[i].exp_inst);
            check($sformatf("v%0d_err_count", i), 32'(err_count), 32'(err_exp));
            tick();
            check($sformatf("v%0d_idle_valid", i), 32'(out_valid), 32'd0);
            check($sformatf("v%0d_idle_except", i), 32'(except), 32'd0);
        end

        // Fill to DEPTH with the consumer stalled, then drain
        out_ready = 1'b0;
        q.delete();
        for (int k = 0; k < 4; k++) begin
            req_add(k);
            in_valid = 1'b1;
            check($sformatf("fill%0d_in_ready", k), 32'(in_ready), 32'd1);
            q.push_back(w(k));
            tick();
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_head", out_inst, w(0));
        req_add(4);
        q.push_back(w(4));
        tick(); tick();
        check("full_hold_in_ready", 32'(in_ready), 32'd0);
        check("full_hold_head", out_inst, w(0));
        out_ready = 1'b1;
        acc5 = 1'b0;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            acc = in_valid && in_ready;
            popping = out_valid;
            if (out_valid) check($sformatf("drain_c%0d", c), out_inst, q[0]);
            tick();
            if (popping) tmp = q.pop_front();
            if (acc) begin in_valid = 1'b0; acc5 = 1'b1; end
        end
        check("drain_remaining", 32'(q.size()), 32'd0);
        check("fifth_accepted", 32'(acc5), 32'd1);
        check("drain_empty", 32'(out_valid), 32'd0);

        // Streaming push+pop with two words queued
        out_ready = 1'b0;
        q.delete();
        for (int k = 10; k < 12; k++) begin
            req_add(k);
            in_valid = 1'b1;
            q.push_back(w(k));
            tick();
        end
        out_ready = 1'b1;
        for (int k = 12; k < 18; k++) begin
            req_add(k);
            in_valid = 1'b1;
            check($sformatf("stream%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stream%0d_in_ready", k), 32'(in_ready), 32'd1);
            check($sformatf("stream%0d_inst", k), out_inst, q[0]);
            q.push_back(w(k));
            tick();
            tmp = q.pop_front();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("tail%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("tail%0d_inst", k), out_inst, q[0]);
            tick();
            tmp = q.pop_front();
        end
        check("stream_empty", 32'(out_valid), 32'd0);

        // Reset mid-stream: 3 queued, 5 errors, except pending
        out_ready = 1'b0;
        for (int k = 20; k < 23; k++) begin
            req_add(k);
            in_valid = 1'b1;
            tick();
        end
        set_req(3'd1, 1'b0, 5'd1, 5'd1, 5'd1, 16'h0);
        tick();
        in_valid = 1'b0;
        check("pre_rst_err", 32'(err_count), 32'd5);
        check("pre_rst_except", 32'(except), 32'd1);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_head", out_inst, w(20));
        reset = 1'b0;
        in_valid = 1'b1;
        req_add(30);
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_err", 32'(err_count), 32'd0);
        check("mid_rst_except", 32'(except), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Error counter saturation
        set_req(3'd0, 1'b1, 5'd0, 5'd0, 5'd0, 16'h0);
        in_valid = 1'b1;
        for (int c = 0; c < 260; c++) tick();
        in_valid = 1'b0;
        check("sat_err_count", 32'(err_count), 32'd255);
        check("sat_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("sat_hold", 32'(err_count), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
